// File: rtl/plab3_mem_line_mem_responder.sv
// Line-granularity memory responder: one outstanding 128-bit line
// request at a time, answered after a fixed programmable delay.
module plab3_mem_line_mem_responder #(
    parameter int p_opaque_nbits = 8,
    parameter int p_num_lines    = 64,
    parameter int p_latency      = 2,
    localparam int REQ_NBITS     = 3 + p_opaque_nbits + 32 + 4 + 128,
    localparam int RESP_NBITS    = 3 + p_opaque_nbits + 4 + 128
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  memreq_val,
    output logic                  memreq_rdy,
    input  logic [REQ_NBITS-1:0]  memreq_msg,
    output logic                  memresp_val,
    input  logic                  memresp_rdy,
    output logic [RESP_NBITS-1:0] memresp_msg
);

    localparam int IW = $clog2(p_num_lines);
    localparam logic [3:0] LAT = 4'(p_latency);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t state;
    state_t state_next;

    logic [3:0]                count;
    logic [2:0]                resp_type;
    logic [p_opaque_nbits-1:0] resp_opaque;
    logic [127:0]              resp_data;
    logic [127:0]              mem [p_num_lines];

    logic [2:0]                req_type;
    logic [p_opaque_nbits-1:0] req_opaque;
    logic [31:0]               req_addr;
    logic [127:0]              req_data;
    logic [IW-1:0]             idx;
    logic                      accept;
    logic                      unused;

    assign req_type   = memreq_msg[REQ_NBITS-1 -: 3];
    assign req_opaque = memreq_msg[REQ_NBITS-4 -: p_opaque_nbits];
    assign req_addr   = memreq_msg[132 +: 32];
    assign req_data   = memreq_msg[127:0];
    assign idx        = req_addr[4 +: IW];

    // Offset bits, high address bits and len never matter for a line op.
    assign unused = ^{req_addr, memreq_msg[131:128]};

    // Handshake outputs are decoded from state only; ready is masked in reset.
    assign memreq_rdy  = reset & (state == IDLE);
    assign memresp_val = (state == RESP);
    assign memresp_msg = {resp_type, resp_opaque, 4'd0, resp_data};
    assign accept      = memreq_val & memreq_rdy;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state logic: accept, count down the delay, wait for the taker.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (accept) state_next = (p_latency == 0) ? RESP : WAIT;
            end
            WAIT: begin
                if (count == 4'd1) state_next = RESP;
            end
            RESP: begin
                if (memresp_rdy) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Delay counter: loaded on accept, decremented while waiting.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)               count <= 4'd0;
        else if (accept)          count <= LAT;
        else if (state == WAIT)   count <= count - 4'd1;
    end

    // Response registers: capture header and pre-edge line contents.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            resp_type   <= 3'd0;
            resp_opaque <= '0;
            resp_data   <= '0;
        end else if (accept) begin
            resp_type   <= req_type;
            resp_opaque <= req_opaque;
            resp_data   <= (req_type == 3'd0) ? mem[idx] : '0;
        end
    end

    // Line storage: full-line writes, deliberately not reset.
    always_ff @(posedge clk) begin
        if (accept && req_type == 3'd1) mem[idx] <= req_data;
    end

endmodule

// File: tb/tb_plab3_mem_line_mem_responder.sv
// Randomized bench for the line memory responder, checked against a
// line-array model of the store and the fixed response timing.
module tb_plab3_mem_line_mem_responder;

    localparam int O     = 8;
    localparam int LINES = 64;
    localparam int LAT   = 2;
    localparam int REQW  = 3 + O + 32 + 4 + 128;
    localparam int RSPW  = 3 + O + 4 + 128;

    logic            clk;
    logic            reset;
    logic            memreq_val;
    logic            memreq_rdy;
    logic [REQW-1:0] memreq_msg;
    logic            memresp_val;
    logic            memresp_rdy;
    logic [RSPW-1:0] memresp_msg;

    int total = 0;
    int bad   = 0;

    logic [127:0] model [LINES];

    plab3_mem_line_mem_responder #(
        .p_opaque_nbits (O),
        .p_num_lines    (LINES),
        .p_latency      (LAT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .memreq_val  (memreq_val),
        .memreq_rdy  (memreq_rdy),
        .memreq_msg  (memreq_msg),
        .memresp_val (memresp_val),
        .memresp_rdy (memresp_rdy),
        .memresp_msg (memresp_msg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] got,
                         input logic [255:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // One full transaction; called and returning on a negedge.
    task automatic txn(input logic [2:0] t, input logic [O-1:0] op,
                       input logic [31:0] a, input logic [127:0] d,
                       input int hold);
        int n;
        int li;
        logic [127:0] ed;
        logic [RSPW-1:0] exp;
        check("req_rdy_idle", memreq_rdy, 1'b1);
        memreq_val = 1'b1;
        memreq_msg = {t, op, a, 4'($urandom), d};
        li = int'((a / 16) % LINES);
        ed = (t == 3'd0) ? model[li] : 128'd0;
        if (t == 3'd1) model[li] = d;
        exp = {t, op, 4'd0, ed};
        @(negedge clk);
        memreq_val = 1'b0;
        memreq_msg = {$urandom, rnd128()};
        n = 0;
        while (!memresp_val && n < 40) begin
            memresp_rdy = 1'($urandom);
            if (memreq_rdy) check("req_rdy_busy", memreq_rdy, 1'b0);
            n++;
            @(negedge clk);
        end
        memresp_rdy = 1'b0;
        check("resp_seen", memresp_val, 1'b1);
        check("latency", 32'(n), 32'(LAT));
        check("resp_msg", memresp_msg, exp);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_val", memresp_val, 1'b1);
            check("hold_msg", memresp_msg, exp);
            check("hold_rdy", memreq_rdy, 1'b0);
        end
        memresp_rdy = 1'b1;
        @(negedge clk);
        memresp_rdy = 1'b0;
        check("done_val", memresp_val, 1'b0);
        check("done_rdy", memreq_rdy, 1'b1);
    endtask

    initial begin
        logic [127:0] line;
        logic [127:0] la;
        logic [127:0] lb;
        reset       = 1'b0;
        memreq_val  = 1'b0;
        memreq_msg  = '0;
        memresp_rdy = 1'b0;
        repeat (3) @(negedge clk);
        memreq_val = 1'b1;
        #1;
        check("rst_req_rdy", memreq_rdy, 1'b0);
        check("rst_resp_val", memresp_val, 1'b0);
        check("rst_resp_msg", memresp_msg, '0);
        @(negedge clk);
        memreq_val = 1'b0;
        reset = 1'b1;
        #1;
        check("post_rst_rdy", memreq_rdy, 1'b1);
        @(negedge clk);

        for (int i = 0; i < LINES; i++)
            txn(3'd1, O'(i), 32'(i * 16), rnd128(), 0);

        line = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
        txn(3'd1, 8'h12, 32'h40, line, 0);
        txn(3'd0, 8'h34, 32'h4C, rnd128(), 0);
        check("read_40", model[4], line);

        la = rnd128();
        lb = rnd128();
        txn(3'd1, 8'h01, 32'h000, la, 0);
        txn(3'd1, 8'h02, 32'h400, lb, 0);
        txn(3'd0, 8'h03, 32'h000, 128'd0, 0);

        txn(3'd2, 8'h55, 32'h40, rnd128(), 0);
        txn(3'd0, 8'h56, 32'h40, 128'd0, 5);

        memreq_val = 1'b1;
        memreq_msg = {3'd0, 8'h77, 32'h40, 4'd0, 128'd0};
        @(negedge clk);
        memreq_val = 1'b0;
        reset = 1'b0;
        #1;
        check("midrst_val", memresp_val, 1'b0);
        check("midrst_rdy", memreq_rdy, 1'b0);
        check("midrst_msg", memresp_msg, '0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("midrst_rel_rdy", memreq_rdy, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("midrst_no_resp", memresp_val, 1'b0);
        end
        txn(3'd0, 8'h78, 32'h4F, 128'd0, 1);

        for (int k = 0; k < 300; k++) begin
            logic [2:0] t;
            int r;
            r = int'($urandom_range(0, 9));
            t = (r < 4) ? 3'd0 : (r < 8) ? 3'd1 : 3'($urandom_range(2, 7));
            txn(t, O'($urandom), $urandom, rnd128(),
                int'($urandom_range(0, 3)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
